// File: rtl/instr_decode_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, one-hot op bit indices,
// FIFO occupancy states and the decoded-entry record stored by the skid buffer.
package instr_decode_pkg;

    localparam int NUM_OPS = 31;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bit positions in the one-hot op vector
    localparam int OP_ADD   = 0;
    localparam int OP_ADDU  = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SUBU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_NOR   = 7;
    localparam int OP_SLT   = 8;
    localparam int OP_SLTU  = 9;
    localparam int OP_SLL   = 10;
    localparam int OP_SRL   = 11;
    localparam int OP_SRA   = 12;
    localparam int OP_SLLV  = 13;
    localparam int OP_SRLV  = 14;
    localparam int OP_SRAV  = 15;
    localparam int OP_ADDI  = 16;
    localparam int OP_ADDIU = 17;
    localparam int OP_ANDI  = 18;
    localparam int OP_ORI   = 19;
    localparam int OP_XORI  = 20;
    localparam int OP_SLTI  = 21;
    localparam int OP_SLTIU = 22;
    localparam int OP_LUI   = 23;
    localparam int OP_LW    = 24;
    localparam int OP_SW    = 25;
    localparam int OP_BEQ   = 26;
    localparam int OP_BNE   = 27;
    localparam int OP_J     = 28;
    localparam int OP_JAL   = 29;
    localparam int OP_JR    = 30;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [NUM_OPS-1:0] op;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic [4:0]         shamt;
        logic [15:0]        imm16;
        logic [25:0]        target;
        logic [31:0]        pc;
        logic               illegal;
    } entry_t;

endpackage

// File: rtl/instr_decode_op_lookup.sv
// Combinational instruction-to-entry decode; zero latency, no flow control.
// Only opcode (and funct under SPECIAL) select the op bit; unknown codes give op=0.
module op_lookup
    import instr_decode_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output entry_t      entry
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [NUM_OPS-1:0] op;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        op = '0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                FN_ADD:  op[OP_ADD]  = 1'b1;
                FN_ADDU: op[OP_ADDU] = 1'b1;
                FN_SUB:  op[OP_SUB]  = 1'b1;
                FN_SUBU: op[OP_SUBU] = 1'b1;
                FN_AND:  op[OP_AND]  = 1'b1;
                FN_OR:   op[OP_OR]   = 1'b1;
                FN_XOR:  op[OP_XOR]  = 1'b1;
                FN_NOR:  op[OP_NOR]  = 1'b1;
                FN_SLT:  op[OP_SLT]  = 1'b1;
                FN_SLTU: op[OP_SLTU] = 1'b1;
                FN_SLL:  op[OP_SLL]  = 1'b1;
                FN_SRL:  op[OP_SRL]  = 1'b1;
                FN_SRA:  op[OP_SRA]  = 1'b1;
                FN_SLLV: op[OP_SLLV] = 1'b1;
                FN_SRLV: op[OP_SRLV] = 1'b1;
                FN_SRAV: op[OP_SRAV] = 1'b1;
                FN_JR:   op[OP_JR]   = 1'b1;
                default: ;
            endcase
        end else begin
            case (opcode)
                OPC_ADDI:  op[OP_ADDI]  = 1'b1;
                OPC_ADDIU: op[OP_ADDIU] = 1'b1;
                OPC_ANDI:  op[OP_ANDI]  = 1'b1;
                OPC_ORI:   op[OP_ORI]   = 1'b1;
                OPC_XORI:  op[OP_XORI]  = 1'b1;
                OPC_SLTI:  op[OP_SLTI]  = 1'b1;
                OPC_SLTIU: op[OP_SLTIU] = 1'b1;
                OPC_LUI:   op[OP_LUI]   = 1'b1;
                OPC_LW:    op[OP_LW]    = 1'b1;
                OPC_SW:    op[OP_SW]    = 1'b1;
                OPC_BEQ:   op[OP_BEQ]   = 1'b1;
                OPC_BNE:   op[OP_BNE]   = 1'b1;
                OPC_J:     op[OP_J]     = 1'b1;
                OPC_JAL:   op[OP_JAL]   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        entry         = '0;
        entry.op      = op;
        entry.rs      = instr[25:21];
        entry.rt      = instr[20:16];
        entry.rd      = instr[15:11];
        entry.shamt   = instr[10:6];
        entry.imm16   = instr[15:0];
        entry.target  = instr[25:0];
        entry.pc      = pc;
        entry.illegal = ~|op;
    end

endmodule

// File: rtl/instr_decode.sv
// Decodes accepted instructions into a 2-entry skid FIFO; one cycle accept-to-valid.
// in_ready is registered (low only when both entries are full); flush empties the FIFO.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [30:0]      op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [15:0]      imm16,
    output logic [25:0]      target,
    output logic [31:0]      out_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    entry_t dec;
    entry_t head_q;
    entry_t tail_q;
    occ_t   state;
    logic   push;
    logic   pop;

    op_lookup u_op_lookup (
        .instr (instr),
        .pc    (in_pc),
        .entry (dec)
    );

    // A push coinciding with flush is dropped entirely, including from the count.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head_q    <= dec;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_q <= dec;
                    end else if (push) begin
                        tail_q   <= dec;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_q   <= tail_q;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign op      = head_q.op;
    assign rs      = head_q.rs;
    assign rt      = head_q.rt;
    assign rd      = head_q.rd;
    assign shamt   = head_q.shamt;
    assign imm16   = head_q.imm16;
    assign target  = head_q.target;
    assign out_pc  = head_q.pc;
    assign illegal = head_q.illegal;

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the illegal-instruction counter.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  fetch side offers instr and in_pc.
REQ-005 in_ready  output  1  decoder accepts; a transfer SHALL occur when in_valid and in_ready are both high.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 in_pc  input  32  address of instr.
REQ-008 flush  input  1  discard all buffered entries.
REQ-009 out_valid  output  1  decoded entry present.
REQ-010 out_ready  input  1  controller consumes; a pop SHALL occur when out_valid and out_ready are both high.
REQ-011 op  output  31  one-hot instruction vector, or all-zero for an illegal instruction.
REQ-012 rs, rt, rd, shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6].
REQ-013 imm16  output  16  instr[15:0].
REQ-014 target  output  26  instr[25:0].
REQ-015 out_pc  output  32  in_pc of the head entry.
REQ-016 illegal  output  1  the head entry matched no op bit.
REQ-017 illegal_cnt  output  CNT_W  count of illegal entries accepted.

Function
REQ-018 op bit mapping SHALL be, for opcode 0 by funct: 0 add 0x20, 1 addu 0x21, 2 sub 0x22, 3 subu 0x23, 4 and 0x24, 5 or 0x25, 6 xor 0x26, 7 nor 0x27, 8 slt 0x2A, 9 sltu 0x2B, 10 sll 0x00, 11 srl 0x02, 12 sra 0x03, 13 sllv 0x04, 14 srlv 0x06, 15 srav 0x07, 30 jr 0x08.
REQ-019 By opcode, the mapping SHALL be: 16 addi 0x08, 17 addiu 0x09, 18 andi 0x0C, 19 ori 0x0D, 20 xori 0x0E, 21 slti 0x0A, 22 sltiu 0x0B, 23 lui 0x0F, 24 lw 0x23, 25 sw 0x2B, 26 beq 0x04, 27 bne 0x05, 28 j 0x02, 29 jal 0x03.
REQ-020 Decode SHALL use only opcode, plus funct when the opcode is 0; 0x00000000 SHALL decode as sll and be legal.
REQ-021 At most one op bit SHALL be set; illegal SHALL equal the NOR of op.
REQ-022 Decode SHALL happen at accept time, so the stored entry holds op, the fields, in_pc and illegal.
REQ-023 Buffering SHALL be a 2-entry skid FIFO with states EMPTY, ONE and TWO.
REQ-024 in_ready SHALL be high in EMPTY and ONE, and low in TWO; it SHALL be a register output with no combinational path from out_ready.
REQ-025 out_valid SHALL be high in ONE and TWO; the outputs SHALL present the head entry.
REQ-026 Latency: an accept in EMPTY SHALL give out_valid the next cycle.
REQ-027 Transitions:
- EMPTY: push -> ONE.
- ONE: push only -> TWO; pop only -> EMPTY; push and pop together -> ONE, with the new entry becoming head.
- TWO: pop -> ONE.
REQ-028 Head outputs SHALL stay stable while out_valid is high and out_ready is low.
REQ-029 flush SHALL force EMPTY next cycle; a simultaneous push SHALL be discarded and SHALL NOT be counted.
REQ-030 illegal_cnt SHALL increment on each accepted illegal entry and SHALL saturate at all-ones.
REQ-031 Outputs while out_valid is low SHALL hold their last value; the controller ignores them.

Reset
REQ-032 On rst the block SHALL enter EMPTY, with out_valid=0, in_ready=1, op=0, all fields=0, out_pc=0, illegal=0 and illegal_cnt=0.
REQ-033 Reset mid-operation SHALL drop all buffered entries immediately, regardless of clk.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 A shared package SHALL hold: the opcode and funct constants, the OP_* bit-index constants 0..30, the occupancy state enum, and the decoded-entry struct (op, rs, rt, rd, shamt, imm16, target, pc, illegal).
REQ-036 The combinational instruction-to-entry decode SHALL be one sub-module, op_lookup; the FIFO and the counter SHALL stay in instr_decode.

Verification
REQ-037 Push 0x012A4020 (add $8,$9,$10) at pc 0x00400000, with out_ready=1 -> next cycle out_valid=1, op=1<<0, rs=9, rt=10, rd=8, out_pc=0x00400000.
REQ-038 Push 0x8D090004 (lw), then 0xAD090004 (sw), then 0x1109FFFF (beq), with out_ready=0 -> in_ready drops after two accepts; raising out_ready pops op bits 24, 25, 26 in order.
REQ-039 Push 0xFC000000 -> op=0, illegal=1, illegal_cnt=1; with the counter preset to all-ones, the count stays all-ones.
REQ-040 In state ONE, push 0x0C100000 (jal) with a simultaneous pop -> state stays ONE, head op=1<<29, target=0x0100000.
REQ-041 In TWO, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1, with illegal_cnt unchanged.
REQ-042 Assert rst mid-stream with both entries full -> out_valid=0 immediately and all outputs zero.
